// File: rtl/tape_pkg.sv
// Shared tape-loading constants and player state type for the tape path
// (serial_in, FIFO wrapper, player controller).
package tape_pkg;

  localparam int CLOCK         = 56842105;
  localparam int SAMPLE_RATE   = 44100;
  localparam int SAMPLE_DIV    = CLOCK / SAMPLE_RATE;
  localparam int PREFILL_LEVEL = 512;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREFILL,
    ST_PLAY,
    ST_UNDERRUN
  } tape_state_t;

endpackage

// File: rtl/tape_tick_gen.sv
// Free-running 0..DIV-1 sample counter; o_tick is combinational on the last count.
// No backpressure: the counter only advances while enabled, a sync clear returns it to 0.
module tape_tick_gen #(
  parameter int DIV = 4
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n || i_clear) begin
      count <= '0;
    end else if (i_enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign o_tick = i_enable && (count == LAST);

endmodule

// File: rtl/tape_player_ctrl.sv
// Tape EAR source: live level in normal mode, FIFO playback at SAMPLE_DIV pacing in turbo mode.
// Level changes 1 cycle after a read; an empty FIFO at a tick stalls playback until it refills.
module tape_player_ctrl
  import tape_pkg::*;
#(
  parameter int CLOCK         = tape_pkg::CLOCK,
  parameter int SAMPLE_RATE   = tape_pkg::SAMPLE_RATE,
  parameter int PREFILL_LEVEL = tape_pkg::PREFILL_LEVEL,
  parameter int SAMPLE_DIV    = CLOCK / SAMPLE_RATE
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_load_turbo,
  input  logic        i_tape_direct,
  input  logic [7:0]  i_fifo_q,
  input  logic [10:0] i_fifo_usedw,
  input  logic        i_fifo_empty,
  output logic        o_fifo_read_req,
  output logic        o_fifo_clear,
  output logic        o_tape_in,
  output logic        o_playing,
  output logic        o_underrun
);

  localparam logic [10:0] PREFILL_W = 11'(PREFILL_LEVEL);

  tape_state_t state;
  logic        level;
  logic        tick;
  logic        prefilled;
  logic        unused_q;

  assign prefilled = (i_fifo_usedw >= PREFILL_W);
  assign unused_q  = ^i_fifo_q[6:0];

  tape_tick_gen #(
    .DIV(SAMPLE_DIV)
  ) u_tick_gen (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_enable (state == ST_PLAY),
    .i_clear  ((state != ST_PLAY) || !i_load_turbo),
    .o_tick   (tick)
  );

  // The show-ahead head word is sampled and consumed in the tick cycle itself.
  assign o_fifo_read_req = i_reset_n && i_load_turbo && tick && !i_fifo_empty;
  assign o_tape_in       = (state == ST_IDLE) ? i_tape_direct : level;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state        <= ST_IDLE;
      level        <= 1'b0;
      o_fifo_clear <= 1'b0;
      o_playing    <= 1'b0;
      o_underrun   <= 1'b0;
    end else begin
      o_fifo_clear <= 1'b0;
      if (state != ST_IDLE && !i_load_turbo) begin
        state        <= ST_IDLE;
        o_fifo_clear <= 1'b1;
        o_playing    <= 1'b0;
        o_underrun   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_load_turbo) state <= ST_PREFILL;
          end
          ST_PREFILL, ST_UNDERRUN: begin
            if (prefilled) begin
              state     <= ST_PLAY;
              o_playing <= 1'b1;
            end
          end
          ST_PLAY: begin
            if (tick) begin
              if (!i_fifo_empty) begin
                level <= i_fifo_q[7];
              end else begin
                state      <= ST_UNDERRUN;
                o_playing  <= 1'b0;
                o_underrun <= 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tape_player_ctrl.sv
// Bench for tape_player_ctrl: directed scenarios plus random traffic against a cycle-level reference model.
module tb_tape_player_ctrl;

  localparam int DIV = 4;
  localparam int PRE = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_turbo;
  logic        tape_direct;
  logic [7:0]  fifo_q;
  logic [10:0] fifo_usedw;
  logic        fifo_empty;
  logic        read_req;
  logic        fifo_clear;
  logic        tape_in;
  logic        playing;
  logic        underrun;

  always #5 clk = ~clk;

  tape_player_ctrl #(
    .CLOCK        (4000),
    .SAMPLE_RATE  (1000),
    .PREFILL_LEVEL(PRE),
    .SAMPLE_DIV   (DIV)
  ) dut (
    .i_clock        (clk),
    .i_reset_n      (rst_n),
    .i_load_turbo   (load_turbo),
    .i_tape_direct  (tape_direct),
    .i_fifo_q       (fifo_q),
    .i_fifo_usedw   (fifo_usedw),
    .i_fifo_empty   (fifo_empty),
    .o_fifo_read_req(read_req),
    .o_fifo_clear   (fifo_clear),
    .o_tape_in      (tape_in),
    .o_playing      (playing),
    .o_underrun     (underrun)
  );

  logic [7:0] fq[$];
  logic       seq[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         reads    = 0;
  int         reads_before;
  bit         checking = 0;
  bit         prev_rd  = 0;

  // Reference model: turbo session active, playing, sticky underrun, level, clear pulse,
  // and cycles elapsed since the current playback run began.
  bit m_active, m_playing, m_underrun, m_level, m_clear;
  int m_pcyc;

  function automatic bit m_tick();
    return m_playing && ((m_pcyc % DIV) == DIV - 1);
  endfunction

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got == exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  // Called at a negedge with inputs set; checks outputs, crosses one posedge, advances FIFO and model.
  task automatic cycle();
    logic rd, clr, e_rd, e_tape;
    fifo_empty = (fq.size() == 0);
    fifo_usedw = 11'(fq.size());
    fifo_q     = fifo_empty ? 8'h00 : fq[0];
    #1;
    e_tape = m_active ? m_level : tape_direct;
    e_rd   = rst_n && load_turbo && m_tick() && !fifo_empty;
    rd     = read_req;
    clr    = fifo_clear;
    if (prev_rd) seq.push_back(tape_in);
    if (checking) begin
      chk("tape_in",  tape_in,    e_tape);
      chk("read_req", read_req,   e_rd);
      chk("clear",    fifo_clear, m_clear);
      chk("playing",  playing,    m_playing);
      chk("underrun", underrun,   m_underrun);
    end
    @(posedge clk);
    prev_rd = rd;
    if (rd && fq.size() > 0) begin
      void'(fq.pop_front());
      reads++;
    end
    if (clr) fq.delete();
    if (!rst_n) begin
      m_active = 0; m_playing = 0; m_underrun = 0; m_level = 0; m_clear = 0; m_pcyc = 0;
    end else begin
      m_clear = 0;
      if (!m_active) begin
        m_active = load_turbo;
      end else if (!load_turbo) begin
        m_active = 0; m_playing = 0; m_clear = 1; m_underrun = 0;
      end else if (m_playing) begin
        if (m_tick()) begin
          if (!fifo_empty) m_level = fifo_q[7];
          else begin
            m_underrun = 1;
            m_playing  = 0;
          end
        end
        m_pcyc++;
      end else if (int'(fifo_usedw) >= PRE) begin
        m_playing = 1;
        m_pcyc    = 0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst_n = 0; load_turbo = 0; tape_direct = 0;
    fifo_q = 8'h00; fifo_usedw = '0; fifo_empty = 1'b1;
    @(negedge clk);
    cycle();
    checking = 1;
    cycle();
    rst_n = 1;

    // Normal mode: output tracks the live level, no FIFO traffic.
    for (int i = 0; i < 16; i++) begin
      tape_direct = 1'($urandom_range(0, 1));
      cycle();
    end
    chk_int("normal_reads", reads, 0);

    // Turbo playback of 0x80,0x00,0x80.
    tape_direct = 0;
    fq = '{8'h80, 8'h00, 8'h80};
    seq.delete();
    load_turbo = 1;
    for (int i = 0; i < 15; i++) cycle();
    chk_int("play_reads", reads, 3);
    chk_int("play_seq_len", seq.size(), 3);
    if (seq.size() == 3) begin
      chk("play_seq0", seq[0], 1'b1);
      chk("play_seq1", seq[1], 1'b0);
      chk("play_seq2", seq[2], 1'b1);
    end

    // Empty at tick -> underrun; refill -> resume.
    for (int i = 0; i < 4; i++) cycle();
    chk("underrun_set", underrun, 1'b1);
    for (int i = 0; i < 3; i++) fq.push_back(8'($urandom));
    for (int i = 0; i < 8; i++) cycle();

    // Turbo dropped exactly on a tick.
    for (int i = 0; i < 5; i++) fq.push_back(8'($urandom));
    for (int i = 0; i < 12 && !m_tick(); i++) cycle();
    chk("tick_found", m_tick(), 1'b1);
    reads_before = reads;
    load_turbo = 0;
    cycle();
    chk_int("drop_no_read", reads, reads_before);
    for (int i = 0; i < 3; i++) cycle();

    // Reset mid-play, release with turbo held high.
    for (int i = 0; i < 6; i++) fq.push_back(8'hFF);
    load_turbo = 1;
    for (int i = 0; i < 9; i++) cycle();
    rst_n = 0;
    tape_direct = 0;
    cycle();
    rst_n = 1;
    tape_direct = 1;
    for (int i = 0; i < 4; i++) cycle();

    // Prefill threshold never reached.
    load_turbo = 0;
    cycle();
    cycle();
    fq = '{8'h80, 8'h80};
    load_turbo = 1;
    reads_before = reads;
    for (int i = 0; i < 40; i++) cycle();
    chk_int("prefill_hold_reads", reads, reads_before);
    chk("prefill_not_playing", playing, 1'b0);

    // Random traffic: fast refill first half, starved second half.
    for (int i = 0; i < 1500; i++) begin
      tape_direct = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) load_turbo = ~load_turbo;
      rst_n = ($urandom_range(0, 299) != 0);
      if (fq.size() < 8 && $urandom_range(0, (i < 750) ? 5 : 15) == 0)
        fq.push_back(8'($urandom));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
